// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefWidth  = 8;

  // Output register occupancy.
  typedef enum logic [0:0] {StIdle, StFull} arb_state_e;

  // Round-robin pointer increment with wrap at num.
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned num);
    return (ptr == num - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/sink bus for rr_mux_arbiter.
// With RR_MUX_ARBITER_LOCK_EN defined, a per-requester lock vector is added.
interface rr_mux_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_src;
  logic                     out_ready;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic [NUM_REQ-1:0]       lock;
`endif

  // Requesters and sink side.
  modport master (
    output req, in_data, out_ready,
    input  ack, out_valid, out_data, out_src
`ifdef RR_MUX_ARBITER_LOCK_EN
    , output lock
`endif
  );

  // Arbiter side.
  modport slave (
    input  req, in_data, out_ready,
    output ack, out_valid, out_data, out_src
`ifdef RR_MUX_ARBITER_LOCK_EN
    , input lock
`endif
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any_req
);

  logic [SEL_W:0]   idx;
  logic [SEL_W-1:0] cand;

  // Scan NUM_REQ positions starting at rr_ptr; keep the first hit.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (idx >= (SEL_W + 1)'(NUM_REQ)) idx = idx - (SEL_W + 1)'(NUM_REQ);
      cand = idx[SEL_W-1:0];
      if (!any_req && req[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N-to-1 mux into a one-deep output register.
// Optional owner lock is enabled by defining RR_MUX_ARBITER_LOCK_EN.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned WIDTH   = DefWidth,
  localparam int unsigned SEL_W  = $clog2(NUM_REQ)
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] rr_idx, pick;
  logic             rr_any, any_req, can_load, load;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .pick    (rr_idx),
    .any_req (rr_any)
  );

`ifdef RR_MUX_ARBITER_LOCK_EN
  logic             locked_q, locked_d;
  logic [SEL_W-1:0] owner_q, owner_d;

  // While locked only the owner may win; an idle owner stalls everyone.
  assign pick    = locked_q ? owner_q : rr_idx;
  assign any_req = locked_q ? bus.req[owner_q] : rr_any;
`else
  assign pick    = rr_idx;
  assign any_req = rr_any;
`endif

  assign can_load = (state_q == StIdle) || bus.out_ready;
  // rst_n gating keeps ack low while reset is asserted.
  assign load     = can_load && any_req && rst_n;

  // Data mux and one-hot ack for the current winner.
  always_comb begin
    sel_data = '0;
    bus.ack  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == SEL_W'(i)) begin
        sel_data   = bus.in_data[i*WIDTH +: WIDTH];
        bus.ack[i] = load;
      end
    end
  end

  // Next-state: capture on load, drain on idle load slot, otherwise hold.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
`ifdef RR_MUX_ARBITER_LOCK_EN
    locked_d    = locked_q;
    owner_d     = owner_q;
`endif
    if (load) begin
      out_data_d  = sel_data;
      out_src_d   = pick;
      out_valid_d = 1'b1;
      state_d     = StFull;
`ifdef RR_MUX_ARBITER_LOCK_EN
      if (bus.lock[pick]) begin
        locked_d = 1'b1;
        owner_d  = pick;
      end else begin
        locked_d = 1'b0;
        rr_ptr_d = SEL_W'(ptr_inc(32'(pick), NUM_REQ));
      end
`else
      rr_ptr_d = SEL_W'(ptr_inc(32'(pick), NUM_REQ));
`endif
    end else if (can_load) begin
      out_valid_d = 1'b0;
      state_d     = StIdle;
    end
  end

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
      locked_q    <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
`ifdef RR_MUX_ARBITER_LOCK_EN
      locked_q    <= locked_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule
